alu_seq: RTL and testbench

- Issue-side controller for the 16-bit combinational ALU: the end of the ALU interface that produces operands and the 3-bit op select, and consumes the result.
- Holds an 8x16 register file. Accepts register-to-register instructions over a valid/ready handshake.
- Drives the ALU's a, b and sel inputs, captures the ALU result, writes it back, and returns it over a result valid/ready handshake.
- The ALU itself is instantiated beside this block at top level; this block does not instantiate it.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_seq_regfile.sv | 32 +++
 rtl/alu_seq.sv | 135 +++++++++++++
 tb/tb_alu_seq.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU and its issue-side controller.
package alu_pkg;

    localparam int unsigned W    = 16;
    localparam int unsigned NREG = 8;
    localparam int unsigned RW   = 3;
    localparam int unsigned OPW  = 3;
    localparam int unsigned IW   = 16;

    // Instruction field positions: [15:13] op, [12:10] rd, [9:7] ra, [6:4] rb, [3] wb_en
    localparam int unsigned OP_LSB  = 13;
    localparam int unsigned RD_LSB  = 10;
    localparam int unsigned RA_LSB  = 7;
    localparam int unsigned RB_LSB  = 4;
    localparam int unsigned WB_BIT  = 3;
    localparam int unsigned RSVD_W  = 3;

    typedef enum logic [OPW-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_CMP = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        op_t           op;
        logic [RW-1:0] rd;
        logic [RW-1:0] ra;
        logic [RW-1:0] rb;
        logic          wb_en;
    } instr_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// 8x16 register file: two combinational read ports, one synchronous write port.
module alu_seq_regfile
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [RW-1:0] raddr_a,
    input  logic [RW-1:0] raddr_b,
    output logic [W-1:0]  rdata_a_c,
    output logic [W-1:0]  rdata_b_c
);

    logic [W-1:0] mem_q [NREG];

    // Storage with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a_c = mem_q[raddr_a];
    assign rdata_b_c = mem_q[raddr_b];

endmodule

// File: rtl/alu_seq.sv
// Issue-side ALU controller: accepts reg-to-reg instructions, drives the
// external ALU, writes back the result and returns it over a handshake.
module alu_seq
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_valid,
    input  logic [RW-1:0]   ld_addr,
    input  logic [W-1:0]    ld_data,
    output logic            ld_ready,
    input  logic            instr_valid,
    input  logic [IW-1:0]   instr,
    output logic            instr_ready,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    output logic [OPW-1:0]  alu_sel,
    input  logic [W-1:0]    alu_out,
    output logic            res_valid,
    output logic [W-1:0]    res_data,
    output logic [RW-1:0]   res_rd,
    input  logic            res_ready
);

    state_t        state_q, state_d;
    instr_t        op_q;
    logic          accept;
    logic          rf_we;
    logic [RW-1:0] rf_waddr;
    logic [W-1:0]  rf_wdata;
    logic [W-1:0]  rf_rdata_a;
    logic [W-1:0]  rf_rdata_b;
    logic          unused_rsvd;

    assign unused_rsvd = ^instr[RSVD_W-1:0];

    alu_seq_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we        (rf_we),
        .waddr     (rf_waddr),
        .wdata     (rf_wdata),
        .raddr_a   (op_q.ra),
        .raddr_b   (op_q.rb),
        .rdata_a_c (rf_rdata_a),
        .rdata_b_c (rf_rdata_b)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake readies and register-file write mux (load vs write-back)
    always_comb begin
        state_d     = state_q;
        ld_ready    = 1'b0;
        instr_ready = 1'b0;
        accept      = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        case (state_q)
            IDLE: begin
                ld_ready    = 1'b1;
                instr_ready = !ld_valid;
                if (ld_valid) begin
                    rf_we    = 1'b1;
                    rf_waddr = ld_addr;
                    rf_wdata = ld_data;
                end else if (instr_valid) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = EXEC;
            end
            EXEC: begin
                state_d = RESP;
                if (op_q.wb_en) begin
                    rf_we    = 1'b1;
                    rf_waddr = op_q.rd;
                    rf_wdata = alu_out;
                end
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Instruction latch, ALU operand registers and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_rd    <= '0;
        end else begin
            if (accept) begin
                op_q.op    <= op_t'(instr[OP_LSB +: OPW]);
                op_q.rd    <= instr[RD_LSB +: RW];
                op_q.ra    <= instr[RA_LSB +: RW];
                op_q.rb    <= instr[RB_LSB +: RW];
                op_q.wb_en <= instr[WB_BIT];
            end
            if (state_q == ISSUE) begin
                alu_a   <= rf_rdata_a;
                alu_b   <= rf_rdata_b;
                alu_sel <= OPW'(op_q.op);
            end
            if (state_q == EXEC) begin
                res_data  <= alu_out;
                res_rd    <= op_q.rd;
                res_valid <= 1'b1;
            end else if (state_q == RESP && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq with a behavioural ALU beside it.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_sel;
    logic [15:0] alu_out;
    logic        res_valid;
    logic [15:0] res_data;
    logic [2:0]  res_rd;
    logic        res_ready;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  rd;
    } exp_t;

    exp_t        exp_q [$];
    logic [15:0] mregs [8];
    int          n_pass  = 0;
    int          n_total = 0;
    int          hs_cnt  = 0;
    bit          rand_rdy = 1'b0;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk         (clk),
        .rst         (rst),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_out     (alu_out),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_rd      (res_rd),
        .res_ready   (res_ready)
    );

    // Reference ALU semantics from plain arithmetic
    function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [2:0] sel);
        case (sel)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SHL:  return (b >= 16) ? 16'h0000 : (a << b);
            OP_SHR:  return (b >= 16) ? 16'h0000 : (a >> b);
            default: return (a == b) ? 16'd0 : ((a > b) ? 16'd1 : 16'd2);
        endcase
    endfunction

    always_comb alu_out = alu_fn(alu_a, alu_b, alu_sel);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] rnd_data();
        case ($urandom_range(0, 2))
            0:       return 16'($urandom);
            1:       return 16'($urandom_range(0, 20));
            default: return 16'hFFFF;
        endcase
    endfunction

    // Wait until the controller is idle with no pending result; ends just after a posedge
    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = ld_ready && !res_valid;
        end
        if (!done) chk("idle_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic load(input logic [2:0] addr, input logic [15:0] data);
        bit acc = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = addr;
        ld_data  = data;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = ld_ready;
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        if (acc) mregs[addr] = data;
        else chk("load_timeout", 32'd0, 32'd1);
    endtask

    // Offer one instruction; hold=1 returns right after acceptance (controller in ISSUE)
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb, input logic wb, input bit hold);
        logic [15:0] a, b, e;
        bit acc = 1'b0;
        instr       = {op, rd, ra, rb, wb, 3'($urandom)};
        instr_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = instr_ready;
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        if (!acc) begin
            chk("instr_accept_timeout", 32'd0, 32'd1);
            return;
        end
        a = mregs[ra];
        b = mregs[rb];
        e = alu_fn(a, b, op);
        exp_q.push_back('{e, rd});
        if (wb) mregs[rd] = e;
        if (hold) return;
        @(negedge clk);
        chk("issue_res_valid", 32'(res_valid), 32'd0);
        chk("issue_instr_ready", 32'(instr_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("exec_alu_a", 32'(alu_a), 32'(a));
        chk("exec_alu_b", 32'(alu_b), 32'(b));
        chk("exec_alu_sel", 32'(alu_sel), 32'(op));
        chk("exec_res_valid", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("resp_res_valid", 32'(res_valid), 32'd1);
        wait_idle();
    endtask

    // Scoreboard monitor: compares each result at its handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && res_valid && res_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    chk("res_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_data", 32'(res_data), 32'(e.data));
                    chk("res_rd", 32'(res_rd), 32'(e.rd));
                end
            end
        end
    end

    // Random result back-pressure
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) res_ready = 1'($urandom);
        end
    end

    initial begin
        int hs0;
        rst = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        instr_valid = 1'b0; instr = '0; res_ready = 1'b1;
        foreach (mregs[i]) mregs[i] = 16'h0000;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_res_rd", 32'(res_rd), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_sel", 32'(alu_sel), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Add then dependent readback
        load(3'd1, 16'h0005);
        load(3'd2, 16'h0003);
        issue(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b1, 1'b0);
        issue(OP_OR, 3'd0, 3'd3, 3'd3, 1'b0, 1'b0);

        // Wrap-around and back-to-back dependency
        load(3'd1, 16'hFFFF);
        load(3'd2, 16'h0001);
        issue(OP_ADD, 3'd1, 3'd1, 3'd2, 1'b1, 1'b0);
        issue(OP_SUB, 3'd4, 3'd1, 3'd2, 1'b1, 1'b0);
        chk("wrap_model_r4", 32'(mregs[4]), 32'h0000FFFF);

        // Compare results and wb_en=0
        load(3'd1, 16'h1234);
        load(3'd2, 16'h1234);
        issue(OP_CMP, 3'd5, 3'd1, 3'd2, 1'b1, 1'b0);
        load(3'd1, 16'h0010);
        load(3'd2, 16'h0002);
        issue(OP_CMP, 3'd5, 3'd1, 3'd2, 1'b1, 1'b0);
        issue(OP_CMP, 3'd1, 3'd2, 3'd1, 1'b0, 1'b0);
        issue(OP_OR, 3'd1, 3'd1, 3'd1, 1'b0, 1'b0);

        // Result stall with competing load and instruction
        load(3'd5, 16'hAAAA);
        res_ready = 1'b0;
        issue(OP_ADD, 3'd5, 3'd5, 3'd5, 1'b1, 1'b1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        ld_valid = 1'b1; ld_addr = 3'd5; ld_data = 16'h1111;
        instr_valid = 1'b1; instr = {OP_XOR, 3'd5, 3'd5, 3'd5, 1'b1, 3'b000};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_res_valid", 32'(res_valid), 32'd1);
            chk("stall_res_data", 32'(res_data), 32'h00005554);
            chk("stall_res_rd", 32'(res_rd), 32'd5);
            chk("stall_instr_ready", 32'(instr_ready), 32'd0);
            chk("stall_ld_ready", 32'(ld_ready), 32'd0);
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        instr_valid = 1'b0;
        hs0 = hs_cnt;
        res_ready = 1'b1;
        wait_idle();
        chk("stall_one_handshake", 32'(hs_cnt - hs0), 32'd1);
        issue(OP_OR, 3'd0, 3'd5, 3'd5, 1'b0, 1'b0);

        // Load and instruction offered together: load first
        ld_valid = 1'b1; ld_addr = 3'd6; ld_data = 16'h0777;
        instr_valid = 1'b1; instr = {OP_ADD, 3'd7, 3'd6, 3'd0, 1'b1, 3'b101};
        @(negedge clk);
        chk("both_instr_ready", 32'(instr_ready), 32'd0);
        chk("both_ld_ready", 32'(ld_ready), 32'd1);
        @(posedge clk); #1;
        ld_valid = 1'b0;
        mregs[6] = 16'h0777;
        @(negedge clk);
        chk("both_instr_ready_next", 32'(instr_ready), 32'd1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        exp_q.push_back('{alu_fn(mregs[6], mregs[0], OP_ADD), 3'd7});
        mregs[7] = alu_fn(mregs[6], mregs[0], OP_ADD);
        wait_idle();

        // Reset during EXEC
        load(3'd1, 16'h1234);
        issue(OP_ADD, 3'd2, 3'd1, 3'd1, 1'b1, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_res_valid", 32'(res_valid), 32'd0);
        chk("midrst_alu_sel", 32'(alu_sel), 32'd0);
        chk("midrst_alu_a", 32'(alu_a), 32'd0);
        chk("midrst_res_data", 32'(res_data), 32'd0);
        chk("midrst_idle", 32'(ld_ready), 32'd1);
        foreach (mregs[i]) mregs[i] = 16'h0000;
        @(posedge clk); #1;
        issue(OP_OR, 3'd0, 3'd1, 3'd1, 1'b0, 1'b0);
        issue(OP_OR, 3'd0, 3'd2, 3'd7, 1'b0, 1'b0);
        load(3'd3, 16'h0042);
        issue(OP_ADD, 3'd4, 3'd3, 3'd5, 1'b1, 1'b0);

        // Randomized traffic with random back-pressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) load(3'($urandom), rnd_data());
            else issue(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'b0);
        end
        rand_rdy = 1'b0;
        res_ready = 1'b1;
        for (int r = 0; r < 8; r++) issue(OP_OR, 3'd0, 3'(r), 3'(r), 1'b0, 1'b0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
